// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held until ack.
// Re-arbitrates on ack from the slot after the winner, giving back-to-back grants.
module rr_grant_arbiter #(
   parameter int INPUTS = 4,
   localparam int IDW = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INPUTS-1:0] req,
   input  logic              ack,
   output logic [INPUTS-1:0] grant,
   output logic              grant_valid,
   output logic [IDW-1:0]    grant_id
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_e;

   state_e              state_q, state_d;
   logic [IDW-1:0]      ptr_q, ptr_d;
   logic [INPUTS-1:0]   grant_q, grant_d;
   logic                valid_q, valid_d;
   logic [IDW-1:0]      id_q, id_d;

   logic [IDW-1:0]      ptr_inc;
   logic [IDW-1:0]      scan_ptr;
   logic                hi_found, lo_found;
   logic [IDW-1:0]      hi_id, lo_id;
   logic                win_found;
   logic [IDW-1:0]      win_id;
   logic [INPUTS-1:0]   win_vec;

   assign ptr_inc = (id_q == IDW'(INPUTS - 1)) ? '0 : id_q + 1'b1;

   // On ack the scan must already use the advanced pointer.
   assign scan_ptr = (state_q == GRANT) ? ptr_inc : ptr_q;

   // Lowest set index at or above scan_ptr wins; otherwise wrap to lowest set index.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      for (int i = INPUTS - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_found = 1'b1;
            lo_id    = IDW'(i);
            if (IDW'(i) >= scan_ptr) begin
               hi_found = 1'b1;
               hi_id    = IDW'(i);
            end
         end
      end
      win_found = lo_found;
      win_id    = hi_found ? hi_id : lo_id;
   end

   always_comb begin
      win_vec = '0;
      for (int i = 0; i < INPUTS; i++) begin
         win_vec[i] = win_found && (win_id == IDW'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      valid_d = valid_q;
      id_d    = id_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d = win_vec;
               valid_d = 1'b1;
               id_d    = win_id;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (ack) begin
               ptr_d = ptr_inc;
               if (win_found) begin
                  grant_d = win_vec;
                  valid_d = 1'b1;
                  id_d    = win_id;
               end else begin
                  grant_d = '0;
                  valid_d = 1'b0;
                  id_d    = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         id_q    <= id_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = valid_q;
   assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus a long random run
// compared every cycle against a round-robin reference model.
module tb_rr_grant_arbiter;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic         ack;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [1:0]   grant_id;

   int checks = 0;
   int errors = 0;

   int m_valid = 0;
   int m_id    = 0;
   int m_ptr   = 0;

   rr_grant_arbiter #(.INPUTS(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .ack         (ack),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input int p, input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // Reference: first requester at or after the pointer, pointer moves on ack.
   always @(posedge clk or negedge rst_n) begin
      int w;
      if (!rst_n) begin
         m_valid = 0;
         m_id    = 0;
         m_ptr   = 0;
      end else if (m_valid == 0 || ack) begin
         if (m_valid != 0) m_ptr = (m_id + 1) % N;
         w = pick(m_ptr, req);
         m_valid = (w >= 0) ? 1 : 0;
         m_id    = (w >= 0) ? w : 0;
      end
   end

   always @(negedge clk) begin
      logic [31:0] exp_g;
      exp_g = (m_valid != 0) ? (32'd1 << m_id) : 32'd0;
      check("model_grant", 32'(grant), exp_g);
      check("model_valid", 32'(grant_valid), 32'(m_valid));
      check("model_id", 32'(grant_id), 32'(m_id));
      check("onehot0", 32'($onehot0(grant)), 32'd1);
      check("valid_eq_or", 32'(grant_valid), 32'(|grant));
      if (grant_valid) check("grant_at_id", 32'(grant[grant_id]), 32'd1);
   end

   // Inputs set at posedge+2; returns at the following posedge+2.
   task automatic cycle(input logic [N-1:0] r, input logic a);
      req = r;
      ack = a;
      @(posedge clk);
      #2;
   endtask

   task automatic expect_out(input string name, input logic [N-1:0] g,
                             input logic v, input logic [1:0] id);
      check({name, "_grant"}, 32'(grant), 32'(g));
      check({name, "_valid"}, 32'(grant_valid), 32'(v));
      check({name, "_id"}, 32'(grant_id), 32'(id));
   endtask

   initial begin
      bit seen3;
      rst_n = 1'b0;
      req   = 4'b1111;
      ack   = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      expect_out("rst_hold", 4'b0000, 1'b0, 2'd0);
      rst_n = 1'b1;

      cycle(4'b1111, 1'b0);
      expect_out("first", 4'b0001, 1'b1, 2'd0);
      #1 rst_n = 1'b0;
      #1;
      expect_out("async_rst", 4'b0000, 1'b0, 2'd0);
      rst_n = 1'b1;
      cycle(4'b0100, 1'b0);
      expect_out("after_rst", 4'b0100, 1'b1, 2'd2);

      cycle(4'b0100, 1'b0);
      expect_out("hold1", 4'b0100, 1'b1, 2'd2);
      cycle(4'b0000, 1'b0);
      expect_out("hold2", 4'b0100, 1'b1, 2'd2);
      cycle(4'b0000, 1'b0);
      expect_out("hold3", 4'b0100, 1'b1, 2'd2);
      cycle(4'b0000, 1'b1);
      expect_out("ack_idle", 4'b0000, 1'b0, 2'd0);

      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b1);
      expect_out("idle_ack", 4'b0000, 1'b0, 2'd0);
      cycle(4'b0011, 1'b0);
      expect_out("idle_ptr0", 4'b0001, 1'b1, 2'd0);
      cycle(4'b0000, 1'b1);

      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      cycle(4'b1111, 1'b0);
      expect_out("rot0", 4'b0001, 1'b1, 2'd0);
      cycle(4'b1111, 1'b1);
      expect_out("rot1", 4'b0010, 1'b1, 2'd1);
      cycle(4'b1111, 1'b1);
      expect_out("rot2", 4'b0100, 1'b1, 2'd2);
      cycle(4'b1111, 1'b1);
      expect_out("rot3", 4'b1000, 1'b1, 2'd3);
      cycle(4'b1111, 1'b1);
      expect_out("rot4", 4'b0001, 1'b1, 2'd0);

      cycle(4'b1000, 1'b1);
      expect_out("to3", 4'b1000, 1'b1, 2'd3);
      cycle(4'b1001, 1'b1);
      expect_out("wrap", 4'b0001, 1'b1, 2'd0);
      cycle(4'b1001, 1'b1);
      expect_out("skip", 4'b1000, 1'b1, 2'd3);

      cycle(4'b0001, 1'b1);
      cycle(4'b0001, 1'b1);
      expect_out("solo_regrant", 4'b0001, 1'b1, 2'd0);
      seen3 = 1'b0;
      for (int i = 0; i < N && !seen3; i++) begin
         cycle(4'b1001, 1'b1);
         if (grant[3]) seen3 = 1'b1;
      end
      check("fairness", 32'(seen3), 32'd1);
      cycle(4'b0000, 1'b1);
      expect_out("drain", 4'b0000, 1'b0, 2'd0);

      for (int i = 0; i < 10000; i++) begin
         cycle(4'($urandom), ($urandom_range(0, 2) != 0));
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
